// File: rtl/conv1d_seq_pkg.sv
// Shared types and helpers for the Conv1D tile sequencer.
package conv1d_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_I,
        S_LOAD_O,
        S_COMPUTE,
        S_DRAIN,
        S_WRITEBACK,
        S_DONE
    } seq_state_t;

    // Bit positions inside the 3-bit SRAM/L0 enable vectors.
    localparam int unsigned MEM_WEIGHT = 0;
    localparam int unsigned MEM_INPUT  = 1;
    localparam int unsigned MEM_OUTPUT = 2;

    // Address width for an array of n entries; at least 1 bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv1d_tile_sequencer_l0_transfer_counter.sv
// Overhead-then-N transfer counter shared by all load and writeback phases.
// Restarts from zero whenever it is inactive or its phase completes.
module l0_transfer_counter
    import conv1d_seq_pkg::*;
#(
    parameter int unsigned Overhead  = 2,
    parameter int unsigned Max_Words = 5,
    localparam int unsigned IW = addr_w(Max_Words),
    localparam int unsigned CW = addr_w(Overhead + Max_Words + 1) + 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          active,
    input  logic [IW-1:0] last_idx,
    output logic [IW-1:0] idx,
    output logic          access_valid,
    output logic          write_valid,
    output logic [IW-1:0] write_idx,
    output logic          done
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last_access;

    // Decode the current phase cycle into access/done qualifiers.
    always_comb begin
        last_access  = CW'(Overhead) + CW'(last_idx);
        access_valid = active && (cnt >= CW'(Overhead)) && (cnt <= last_access);
        idx          = IW'(cnt - CW'(Overhead));
        done         = active && (cnt == last_access + CW'(1));
    end

    // Phase cycle counter plus the one-cycle write delay line.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt         <= '0;
            write_valid <= 1'b0;
            write_idx   <= '0;
        end else begin
            cnt         <= (!active || done) ? '0 : cnt + CW'(1);
            write_valid <= access_valid;
            write_idx   <= idx;
        end
    end

endmodule

// File: rtl/conv1d_tile_sequencer.sv
// Multi-tile Conv1D sequencer: loads, MAC stepping, partial-sum writeback.
// Optional macro CONV1D_SEQ_PERF_CNT_EN adds load/compute cycle counters.
module conv1d_tile_sequencer
    import conv1d_seq_pkg::*;
#(
    parameter int unsigned Weight_Nums    = 4,
    parameter int unsigned Output_Nums    = 8,
    parameter int unsigned L0_Weight_Nums = 2,
    parameter int unsigned L0_Output_Nums = 4,
    parameter int unsigned Pipeline_Tail  = 3,
    parameter int unsigned Load_Overhead  = 2,
    localparam int unsigned Input_Nums    = Output_Nums + Weight_Nums - 1,
    localparam int unsigned L0_Input_Nums = L0_Weight_Nums + L0_Output_Nums - 1,
    localparam int unsigned AW_MW = addr_w(Weight_Nums),
    localparam int unsigned AW_MI = addr_w(Input_Nums),
    localparam int unsigned AW_MO = addr_w(Output_Nums),
    localparam int unsigned AW_LW = addr_w(L0_Weight_Nums),
    localparam int unsigned AW_LI = addr_w(L0_Input_Nums),
    localparam int unsigned AW_LO = addr_w(L0_Output_Nums)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       Mem_En_R,
    output logic             Mem_En_W,
    output logic [AW_MW-1:0] Mem_Weight_Addr_Read,
    output logic [AW_MI-1:0] Mem_Input_Addr_Read,
    output logic [AW_MO-1:0] Mem_Output_Addr_Read,
    output logic [AW_MO-1:0] Mem_Output_Addr_Write,
    output logic [2:0]       L0_En_W,
    output logic [2:0]       L0_En_R,
    output logic [AW_LW-1:0] L0_Weight_Addr_Write,
    output logic [AW_LW-1:0] L0_Weight_Addr_Read,
    output logic [AW_LI-1:0] L0_Input_Addr_Write,
    output logic [AW_LI-1:0] L0_Input_Addr_Read,
    output logic [AW_LO-1:0] L0_Output_Addr_Write,
    output logic [AW_LO-1:0] L0_Output_Addr_Read,
    output logic             Computing,
    output logic             Initial_Accumulate,
    output logic             Partial_Select
`ifdef CONV1D_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]      Perf_Load_Cycles,
    output logic [31:0]      Perf_Compute_Cycles
`endif
);

    localparam int unsigned WT_TILES = Weight_Nums / L0_Weight_Nums;
    localparam int unsigned OT_TILES = Output_Nums / L0_Output_Nums;
    localparam int unsigned AW_WT    = addr_w(WT_TILES);
    localparam int unsigned AW_OT    = addr_w(OT_TILES);
    localparam int unsigned AW_DR    = addr_w(Pipeline_Tail);
    localparam int unsigned MW1      = AW_MW + 1;
    localparam int unsigned MI1      = AW_MI + 1;
    localparam int unsigned MO1      = AW_MO + 1;
    localparam int unsigned LI1      = AW_LI + 1;

    if ((Weight_Nums % L0_Weight_Nums) != 0) begin : g_bad_lw
        $error("L0_Weight_Nums must divide Weight_Nums");
    end
    if ((Output_Nums % L0_Output_Nums) != 0) begin : g_bad_lo
        $error("L0_Output_Nums must divide Output_Nums");
    end
    if (Pipeline_Tail < 1) begin : g_bad_pt
        $error("Pipeline_Tail must be at least 1");
    end

    seq_state_t       state, state_nxt;
    logic [AW_WT-1:0] wt;
    logic [AW_OT-1:0] ot;
    logic [AW_LW-1:0] w_cnt;
    logic [AW_LO-1:0] o_cnt;
    logic [AW_DR-1:0] dr_cnt;
    logic             wt_last, ot_last, w_last, o_last, dr_last;

    logic [Pipeline_Tail-1:0] sr_v;
    logic [AW_LO-1:0]         sr_o [Pipeline_Tail];

    logic             x_active, x_acc, x_wr, x_done;
    logic [AW_LI-1:0] x_last, x_idx, x_wr_idx;

    l0_transfer_counter #(
        .Overhead  (Load_Overhead),
        .Max_Words (L0_Input_Nums)
    ) u_xfer (
        .clk          (clk),
        .Reset        (Reset),
        .active       (x_active),
        .last_idx     (x_last),
        .idx          (x_idx),
        .access_valid (x_acc),
        .write_valid  (x_wr),
        .write_idx    (x_wr_idx),
        .done         (x_done)
    );

    // Transfer length and wrap flags for the current state.
    always_comb begin
        x_active = 1'b0;
        x_last   = '0;
        case (state)
            S_LOAD_W: begin
                x_active = 1'b1;
                x_last   = AW_LI'(L0_Weight_Nums - 1);
            end
            S_LOAD_I: begin
                x_active = 1'b1;
                x_last   = AW_LI'(L0_Input_Nums - 1);
            end
            S_LOAD_O, S_WRITEBACK: begin
                x_active = 1'b1;
                x_last   = AW_LI'(L0_Output_Nums - 1);
            end
            default: ;
        endcase
        wt_last = (wt == AW_WT'(WT_TILES - 1));
        ot_last = (ot == AW_OT'(OT_TILES - 1));
        w_last  = (w_cnt == AW_LW'(L0_Weight_Nums - 1));
        o_last  = (o_cnt == AW_LO'(L0_Output_Nums - 1));
        dr_last = (dr_cnt == AW_DR'(Pipeline_Tail - 1));
    end

    // Next-state selection for the tile loop.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (Start) state_nxt = S_LOAD_W;
            S_LOAD_W:    if (x_done) state_nxt = S_LOAD_I;
            S_LOAD_I:    if (x_done) state_nxt = (wt != '0) ? S_LOAD_O : S_COMPUTE;
            S_LOAD_O:    if (x_done) state_nxt = S_COMPUTE;
            S_COMPUTE:   if (w_last && o_last) state_nxt = S_DRAIN;
            S_DRAIN:     if (dr_last) state_nxt = S_WRITEBACK;
            S_WRITEBACK: if (x_done) state_nxt = (wt_last && ot_last) ? S_DONE : S_LOAD_W;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State register and tile indices (weight tile inner, output tile outer).
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= S_IDLE;
            wt    <= '0;
            ot    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && Start) begin
                wt <= '0;
                ot <= '0;
            end else if (state == S_WRITEBACK && x_done) begin
                if (wt_last) begin
                    wt <= '0;
                    ot <= ot_last ? '0 : ot + AW_OT'(1);
                end else begin
                    wt <= wt + AW_WT'(1);
                end
            end
        end
    end

    // MAC step counters (o outer, w inner) and drain counter.
    always_ff @(posedge clk) begin
        if (Reset || state != S_COMPUTE) begin
            w_cnt <= '0;
            o_cnt <= '0;
        end else if (w_last) begin
            w_cnt <= '0;
            o_cnt <= o_last ? '0 : o_cnt + AW_LO'(1);
        end else begin
            w_cnt <= w_cnt + AW_LW'(1);
        end
        if (Reset || state != S_DRAIN) begin
            dr_cnt <= '0;
        end else begin
            dr_cnt <= dr_cnt + AW_DR'(1);
        end
    end

    // Delay line that issues the L0 output write Pipeline_Tail cycles after an output's last tap.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sr_v <= '0;
            for (int unsigned i = 0; i < Pipeline_Tail; i++) sr_o[i] <= '0;
        end else begin
            sr_v[0] <= (state == S_COMPUTE) && w_last;
            sr_o[0] <= o_cnt;
            for (int unsigned i = 1; i < Pipeline_Tail; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_o[i] <= sr_o[i-1];
            end
        end
    end

    // Memory/L0 enables and addresses decoded from state and counters.
    always_comb begin
        Busy                  = (state != S_IDLE);
        Done                  = (state == S_DONE);
        Computing             = (state == S_COMPUTE) || (state == S_DRAIN);
        Partial_Select        = (wt != '0);
        Initial_Accumulate    = 1'b0;
        Mem_En_R              = '0;
        Mem_En_W              = 1'b0;
        Mem_Weight_Addr_Read  = '0;
        Mem_Input_Addr_Read   = '0;
        Mem_Output_Addr_Read  = '0;
        Mem_Output_Addr_Write = '0;
        L0_En_W               = '0;
        L0_En_R               = '0;
        L0_Weight_Addr_Write  = '0;
        L0_Weight_Addr_Read   = '0;
        L0_Input_Addr_Write   = '0;
        L0_Input_Addr_Read    = '0;
        L0_Output_Addr_Write  = '0;
        L0_Output_Addr_Read   = '0;
        case (state)
            S_LOAD_W: begin
                Mem_En_R[MEM_WEIGHT]  = x_acc;
                Mem_Weight_Addr_Read  = AW_MW'(MW1'(wt) * MW1'(L0_Weight_Nums) + MW1'(x_idx));
                L0_En_W[MEM_WEIGHT]   = x_wr;
                L0_Weight_Addr_Write  = AW_LW'(x_wr_idx);
            end
            S_LOAD_I: begin
                Mem_En_R[MEM_INPUT]   = x_acc;
                Mem_Input_Addr_Read   = AW_MI'(MI1'(ot) * MI1'(L0_Output_Nums)
                                        + MI1'(wt) * MI1'(L0_Weight_Nums) + MI1'(x_idx));
                L0_En_W[MEM_INPUT]    = x_wr;
                L0_Input_Addr_Write   = x_wr_idx;
            end
            S_LOAD_O: begin
                Mem_En_R[MEM_OUTPUT]  = x_acc;
                Mem_Output_Addr_Read  = AW_MO'(MO1'(ot) * MO1'(L0_Output_Nums) + MO1'(x_idx));
                L0_En_W[MEM_OUTPUT]   = x_wr;
                L0_Output_Addr_Write  = AW_LO'(x_wr_idx);
            end
            S_COMPUTE: begin
                L0_En_R               = '1;
                L0_Weight_Addr_Read   = w_cnt;
                L0_Input_Addr_Read    = AW_LI'(LI1'(o_cnt) + LI1'(w_cnt));
                L0_Output_Addr_Read   = o_cnt;
                Initial_Accumulate    = (w_cnt == '0);
                L0_En_W[MEM_OUTPUT]   = sr_v[Pipeline_Tail-1];
                L0_Output_Addr_Write  = sr_o[Pipeline_Tail-1];
            end
            S_DRAIN: begin
                L0_En_W[MEM_OUTPUT]   = sr_v[Pipeline_Tail-1];
                L0_Output_Addr_Write  = sr_o[Pipeline_Tail-1];
            end
            S_WRITEBACK: begin
                L0_En_R[MEM_OUTPUT]   = x_acc;
                L0_Output_Addr_Read   = AW_LO'(x_idx);
                Mem_En_W              = x_wr;
                Mem_Output_Addr_Write = AW_MO'(MO1'(ot) * MO1'(L0_Output_Nums) + MO1'(x_wr_idx));
            end
            default: ;
        endcase
    end

`ifdef CONV1D_SEQ_PERF_CNT_EN
    // Saturating per-run cycle counters for load/writeback and compute/drain.
    always_ff @(posedge clk) begin
        if (Reset || (state == S_IDLE && Start)) begin
            Perf_Load_Cycles    <= '0;
            Perf_Compute_Cycles <= '0;
        end else begin
            if ((state == S_LOAD_W || state == S_LOAD_I || state == S_LOAD_O ||
                 state == S_WRITEBACK) && Perf_Load_Cycles != '1)
                Perf_Load_Cycles <= Perf_Load_Cycles + 32'd1;
            if (Computing && Perf_Compute_Cycles != '1)
                Perf_Compute_Cycles <= Perf_Compute_Cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv1d_tile_sequencer.sv
// Directed bench for conv1d_tile_sequencer at default parameters.
// Cycle n is the interval after the n-th edge following the Start edge (which is cycle 1).
module tb_conv1d_tile_sequencer;

    logic       clk, Reset, Start;
    logic       Busy, Done, Mem_En_W, Computing, Initial_Accumulate, Partial_Select;
    logic [2:0] Mem_En_R, L0_En_W, L0_En_R;
    logic [1:0] Mem_Weight_Addr_Read;
    logic [3:0] Mem_Input_Addr_Read;
    logic [2:0] Mem_Output_Addr_Read, Mem_Output_Addr_Write;
    logic [0:0] L0_Weight_Addr_Write, L0_Weight_Addr_Read;
    logic [2:0] L0_Input_Addr_Write, L0_Input_Addr_Read;
    logic [1:0] L0_Output_Addr_Write, L0_Output_Addr_Read;
`ifdef CONV1D_SEQ_PERF_CNT_EN
    logic [31:0] Perf_Load_Cycles, Perf_Compute_Cycles;
`endif

    conv1d_tile_sequencer #(
        .Weight_Nums    (4),
        .Output_Nums    (8),
        .L0_Weight_Nums (2),
        .L0_Output_Nums (4),
        .Pipeline_Tail  (3),
        .Load_Overhead  (2)
    ) dut (
        .clk                   (clk),
        .Reset                 (Reset),
        .Start                 (Start),
        .Busy                  (Busy),
        .Done                  (Done),
        .Mem_En_R              (Mem_En_R),
        .Mem_En_W              (Mem_En_W),
        .Mem_Weight_Addr_Read  (Mem_Weight_Addr_Read),
        .Mem_Input_Addr_Read   (Mem_Input_Addr_Read),
        .Mem_Output_Addr_Read  (Mem_Output_Addr_Read),
        .Mem_Output_Addr_Write (Mem_Output_Addr_Write),
        .L0_En_W               (L0_En_W),
        .L0_En_R               (L0_En_R),
        .L0_Weight_Addr_Write  (L0_Weight_Addr_Write),
        .L0_Weight_Addr_Read   (L0_Weight_Addr_Read),
        .L0_Input_Addr_Write   (L0_Input_Addr_Write),
        .L0_Input_Addr_Read    (L0_Input_Addr_Read),
        .L0_Output_Addr_Write  (L0_Output_Addr_Write),
        .L0_Output_Addr_Read   (L0_Output_Addr_Read),
        .Computing             (Computing),
        .Initial_Accumulate    (Initial_Accumulate),
        .Partial_Select        (Partial_Select)
`ifdef CONV1D_SEQ_PERF_CNT_EN
        ,
        .Perf_Load_Cycles      (Perf_Load_Cycles),
        .Perf_Compute_Cycles   (Perf_Compute_Cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        int in_tbl [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
        int wr_exp [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
        int lo_exp [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        int wr_q [$];
        int lo_q [$];
        int first_in, first_ps, stray, wb_cnt;
        logic exp_wr;

        // Reset state
        Reset = 1'b1;
        Start = 1'b0;
        repeat (3) step();
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_mem_en_r", Mem_En_R, 0);
        chk("rst_l0_en", {L0_En_W, L0_En_R}, 0);
        chk("rst_misc", {Mem_En_W, Computing, Initial_Accumulate, Partial_Select}, 0);
        Reset = 1'b0;
        step();
        chk("idle_busy", Busy, 0);

        // Run 1: weight load timing
        Start = 1'b1;
        step();
        Start = 1'b0;
        cyc = 1;
        chk("c1_busy", Busy, 1);
        chk("c1_mem_en_r", Mem_En_R, 0);
        step();
        chk("c2_mem_en_r", Mem_En_R, 0);
        step();
        chk("c3_mem_en_r", Mem_En_R, 3'b001);
        chk("c3_w_addr", Mem_Weight_Addr_Read, 0);
        chk("c3_l0_en_w", L0_En_W, 0);
        step();
        chk("c4_mem_en_r", Mem_En_R, 3'b001);
        chk("c4_w_addr", Mem_Weight_Addr_Read, 1);
        chk("c4_l0_en_w", L0_En_W, 3'b001);
        chk("c4_l0w_addr", L0_Weight_Addr_Write, 0);
        step();
        chk("c5_mem_en_r", Mem_En_R, 0);
        chk("c5_l0_en_w", L0_En_W, 3'b001);
        chk("c5_l0w_addr", L0_Weight_Addr_Write, 1);
        step();
        chk("c6_l0_en_w", L0_En_W, 0);

        // First COMPUTE tile: 8 steps then 3 drain cycles
        while (!Computing && cyc < 60) step();
        chk("compute_start_cycle", cyc, 14);
        for (int j = 0; j < 11; j++) begin
            if (j < 8) begin
                chk("t0_l0_en_r", L0_En_R, 3'b111);
                chk("t0_in_rd", L0_Input_Addr_Read, in_tbl[j]);
                chk("t0_w_rd", L0_Weight_Addr_Read, j % 2);
                chk("t0_o_rd", L0_Output_Addr_Read, j / 2);
                chk("t0_init_acc", Initial_Accumulate, (j % 2 == 0) ? 1 : 0);
                chk("t0_psel", Partial_Select, 0);
            end
            exp_wr = (j >= 4) && (j % 2 == 0);
            chk("t0_l0o_wr_en", L0_En_W, exp_wr ? 3'b100 : 3'b000);
            if (exp_wr) chk("t0_l0o_wr_addr", L0_Output_Addr_Write, (j - 4) / 2);
            step();
        end
        chk("t0_wb_not_computing", Computing, 0);

        // Remainder of run 1: gather SRAM traffic until Done
        first_in = -1;
        first_ps = -1;
        while (!Done && cyc < 400) begin
            if (Mem_En_W) wr_q.push_back(int'(Mem_Output_Addr_Write));
            if (Mem_En_R[2]) lo_q.push_back(int'(Mem_Output_Addr_Read));
            if (Mem_En_R[1] && first_in < 0) first_in = int'(Mem_Input_Addr_Read);
            if (Computing && first_ps < 0) first_ps = int'(Partial_Select);
            step();
        end
        chk("done_cycle", cyc, 139);
        chk("done_pulse", Done, 1);
        chk("t1_input_base", first_in, 2);
        chk("t1_psel", first_ps, 1);
        chk("wb_count", wr_q.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < wr_q.size()) chk("wb_addr", wr_q[i], wr_exp[i]);
        chk("load_o_count", lo_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < lo_q.size()) chk("load_o_addr", lo_q[i], lo_exp[i]);
        step();
        chk("after_done_done", Done, 0);
        chk("after_done_busy", Busy, 0);
`ifdef CONV1D_SEQ_PERF_CNT_EN
        chk("perf_load", Perf_Load_Cycles, 94);
        chk("perf_compute", Perf_Compute_Cycles, 44);
`endif
        repeat (3) step();
        chk("idle_stays", Busy, 0);

        // Run 2: reset in the middle of COMPUTE with L0 writes pending
        Start = 1'b1;
        step();
        Start = 1'b0;
        cyc = 1;
        while (!Computing && cyc < 60) step();
        repeat (5) step();
        chk("mid_compute", Computing, 1);
        Reset = 1'b1;
        step();
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_en", {Mem_En_R, Mem_En_W, L0_En_W, L0_En_R}, 0);
        Reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({Mem_En_R, Mem_En_W, L0_En_W, L0_En_R} != 0 || Busy) stray++;
        end
        chk("rst_no_stray", stray, 0);
`ifdef CONV1D_SEQ_PERF_CNT_EN
        chk("rst_perf", {Perf_Load_Cycles[15:0], Perf_Compute_Cycles[15:0]}, 0);
`endif

        // Run 3: Start held high for the whole run
        Start = 1'b1;
        step();
        cyc = 1;
        repeat (2) step();
        chk("r3_c3_mem_en_r", Mem_En_R, 3'b001);
        chk("r3_c3_w_addr", Mem_Weight_Addr_Read, 0);
        wb_cnt = 0;
        while (!Done && cyc < 400) begin
            if (Mem_En_W) wb_cnt++;
            step();
        end
        chk("r3_done_cycle", cyc, 139);
        chk("r3_wb_count", wb_cnt, 16);
        step();
        chk("r3_idle_busy", Busy, 0);
`ifdef CONV1D_SEQ_PERF_CNT_EN
        chk("r3_perf_load", Perf_Load_Cycles, 94);
        chk("r3_perf_compute", Perf_Compute_Cycles, 44);
`endif
        step();
        chk("r3_restart_busy", Busy, 1);
        Start = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
